// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Shared definitions for the switch ingress queue: the controller state
// encoding, the default geometry of the block and a saturating counter helper.
// No ports; imported by switch_pkt_fifo and switch_ingress_queue.
// -----------------------------------------------------------------------------
package switch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int DEFAULT_ADDR_WIDTH     = 8;
  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_FIFO_DEPTH     = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // Statistics counters stick at 255 rather than wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/switch_pkt_fifo.sv
// -----------------------------------------------------------------------------
// switch_pkt_fifo
// Synchronous show-ahead FIFO holding packed {address,data} packet entries.
// Read and write pointers carry one extra MSB so full and empty can be told
// apart when the index bits are equal.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset, empties the FIFO
//   push   in   write wdata this cycle (ignored when full)
//   wdata  in   WIDTH-bit entry to write
//   pop    in   discard the head entry this cycle (ignored when empty)
//   rdata  out  current head entry, valid while empty is low
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
//   count  out  number of stored entries
// -----------------------------------------------------------------------------
module switch_pkt_fifo
  import switch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ADDR_WIDTH + DEFAULT_DATA_WIDTH,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]     wr_ptr;
  logic [IDX_W:0]     rd_ptr;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[IDX_W-1:0]];

  // Pointer update; resetting the pointers is enough to discard the contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, written only; stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/switch_ingress_queue.sv
// -----------------------------------------------------------------------------
// switch_ingress_queue
// Buffers incoming packets and presents them one at a time to a switch port
// with a single-cycle send request, then waits for the switch to report
// completion. Packets addressed to 0 are discarded without a request.
//
// Optional feature: define SWITCH_INGRESS_TIMEOUT_EN to abandon a packet that
// has waited TIMEOUT_CYCLES cycles without packet_finished (counted as drop).
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   in_valid/in_ready   upstream handshake, transfer when both high at posedge
//   in_address/in_data  incoming packet
//   port_address        destination of the packet being delivered
//   packet_data         payload of the packet being delivered
//   packet_send_req     one-cycle request to the switch
//   packet_finished     switch reports delivery complete
//   busy                a packet is being requested or awaited
//   sent_count          delivered packets (saturating)
//   drop_count          discarded packets (saturating)
// -----------------------------------------------------------------------------
module switch_ingress_queue
  import switch_pkg::*;
#(
  parameter int PORT_ADDR_LENGTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH       = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES   = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PORT_ADDR_LENGTH-1:0] in_address,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic [PORT_ADDR_LENGTH-1:0] port_address,
  output logic [DATA_WIDTH-1:0]       packet_data,
  output logic                        packet_send_req,
  input  logic                        packet_finished,
  output logic                        busy,
  output logic [7:0]                  sent_count,
  output logic [7:0]                  drop_count
);

  localparam int ENTRY_WIDTH = PORT_ADDR_LENGTH + DATA_WIDTH;
  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
  localparam logic [COUNT_WIDTH-1:0] ALMOST_FULL = COUNT_WIDTH'(FIFO_DEPTH - 1);

  state_t                       state;
  logic                         push;
  logic                         pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [COUNT_WIDTH-1:0]       level;
  logic [ENTRY_WIDTH-1:0]       head;
  logic [PORT_ADDR_LENGTH-1:0]  head_address;
  logic [DATA_WIDTH-1:0]        head_data;

  assign push = in_valid && in_ready;
  assign pop  = (state == IDLE) && !fifo_empty;
  assign {head_address, head_data} = head;
  assign busy = (state != IDLE);

  switch_pkt_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({in_address, in_data}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (level)
  );

  // in_ready is the registered "not full" level of the next cycle. A pop from
  // a full FIFO only reopens the input one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready <= 1'b0;
    end else begin
      in_ready <= !((fifo_full && !pop) || ((level == ALMOST_FULL) && push && !pop));
    end
  end

`ifdef SWITCH_INGRESS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_count;
`else
  // Without the timeout the parameter only keeps the interface uniform.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  // Delivery controller. The output registers are loaded only when a packet
  // leaves IDLE for REQ, so they stay stable for the whole REQ/WAIT period.
  // In WAIT a completion takes priority over an expiring timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      packet_send_req <= 1'b0;
      port_address    <= '0;
      packet_data     <= '0;
      sent_count      <= '0;
      drop_count      <= '0;
`ifdef SWITCH_INGRESS_TIMEOUT_EN
      tmo_count       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (head_address != '0) begin
              port_address    <= head_address;
              packet_data     <= head_data;
              packet_send_req <= 1'b1;
              state           <= REQ;
            end else begin
              drop_count <= sat_inc(drop_count);
            end
          end
        end
        REQ: begin
          packet_send_req <= 1'b0;
          state           <= WAIT;
`ifdef SWITCH_INGRESS_TIMEOUT_EN
          tmo_count       <= '0;
`endif
        end
        WAIT: begin
          if (packet_finished) begin
            sent_count <= sat_inc(sent_count);
            state      <= IDLE;
          end
`ifdef SWITCH_INGRESS_TIMEOUT_EN
          else if (tmo_count == TMO_LAST) begin
            drop_count <= sat_inc(drop_count);
            state      <= IDLE;
          end else begin
            tmo_count <= tmo_count + 1'b1;
          end
`endif
        end
        default: begin
          packet_send_req <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
